// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and FSM state encoding shared by the execute-stage ALU/MDU.
package alu_pkg;
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH-1:0] m, src_hi, src_lo, src_m, diff, nhi, nlo;
  logic [WIDTH:0] sum, t;
  logic [CNT_W-1:0] cnt;
  logic div_r, src_div, ge, zdiv;
  // The start edge already performs the first step, so the op spans WIDTH edges in total.
  always_comb begin
    zdiv = div && (b == '0);
    src_div = start ? div : div_r;
    src_hi = start ? '0 : hi;
    src_lo = start ? (div ? a : b) : lo;
    src_m = start ? (div ? b : a) : m;
    sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_m} : '0);
    t = {src_hi, src_lo[WIDTH-1]};
    ge = t >= {1'b0, src_m};
    diff = t[WIDTH-1:0] - src_m;
    {nhi, nlo} = src_div ? {(ge ? diff : t[WIDTH-1:0]), src_lo[WIDTH-2:0], ge}
                         : {sum, src_lo[WIDTH-1:1]};
    done = cnt == CNT_W'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
      m <= '0;
      div_r <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      div_r <= div;
      m <= src_m;
      {hi, lo} <= zdiv ? {a, {WIDTH{1'b1}}} : {nhi, nlo};
      cnt <= zdiv ? '0 : CNT_W'(WIDTH - 1);
    end else if (cnt != '0) begin
      {hi, lo} <= {nhi, nlo};
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered single-cycle ALU plus iterative MULTU/DIVU with HI/LO and valid/ready handshake.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state, state_n;
  logic acc, is_div, is_mdu, zdiv, sub, slt, alu_ovf, mdu_done;
  logic [WIDTH-1:0] bx, sum, alu_res, p_hi, p_lo;
  always_comb begin
    is_div = ctl == OP_DIVU;
    is_mdu = is_div || (ctl == OP_MULTU);
    zdiv = is_div && (b == '0);
    sub = (ctl == OP_SUB) || (ctl == OP_SLT);
    bx = sub ? ~b : b;
    sum = a + bx + WIDTH'(sub);
    alu_ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    slt = sum[WIDTH-1] ^ alu_ovf;
    alu_res = (ctl == OP_OR) ? (a | b)
            : ((ctl == OP_ADD) || (ctl == OP_SUB)) ? sum
            : (ctl == OP_SLT) ? WIDTH'(slt)
            : (ctl == OP_NOR) ? ~(a | b)
            : (a & b);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = (state == IDLE) ? ((!acc || !is_mdu) ? IDLE : zdiv ? DONE : is_div ? DIV : MUL)
            : (state == DONE) ? IDLE
            : mdu_done ? DONE : state;
  end
  always_comb begin
    in_ready = state == IDLE;
    acc = in_valid && in_ready;
  end
  mdu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mdu (
    .clk(clk), .rst(rst), .start(acc && is_mdu), .div(is_div), .a(a), .b(b),
    .done(mdu_done), .hi(p_hi), .lo(p_lo)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      result <= '0;
      zero <= 1'b0;
      ovf <= 1'b0;
      div0 <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      res_valid <= (acc && !is_mdu) || (state == DONE);
      if (acc && !is_mdu) begin
        result <= alu_res;
        zero <= alu_res == '0;
        ovf <= ((ctl == OP_ADD) || (ctl == OP_SUB)) && alu_ovf;
        div0 <= 1'b0;
      end else if (acc) begin
        div0 <= zdiv;
      end
      if (state == DONE) begin
        hi <= p_hi;
        lo <= p_lo;
        result <= p_lo;
        zero <= p_lo == '0;
        ovf <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed checks of alu_mdu at WIDTH=32 and WIDTH=8 driven in lockstep.
module tb_alu_mdu;
  import alu_pkg::*;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [3:0] ctl = '0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, res_valid, zero, ovf, div0;
  logic [31:0] result, hi, lo;
  logic in_ready8, res_valid8, zero8, ovf8, div08;
  logic [7:0] result8, hi8, lo8;
  int n_cmp = 0, n_err = 0, lat, busy, lat8, busy8, cnt;
  logic [3:0] ops [5] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR};
  logic [31:0] exps [5] = '{32'h3, 32'hF, 32'h12, 32'hC, 32'hFFFFFFF0};
  logic [31:0] e;
  always #5 clk = ~clk;
  alu_mdu #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctl(ctl), .a(a), .b(b),
    .res_valid(res_valid), .result(result), .zero(zero), .ovf(ovf), .div0(div0), .hi(hi), .lo(lo)
  );
  alu_mdu #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .ctl(ctl), .a(a[7:0]), .b(b[7:0]),
    .res_valid(res_valid8), .result(result8), .zero(zero8), .ovf(ovf8), .div0(div08), .hi(hi8), .lo(lo8)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    ctl = c;
    a = x;
    b = y;
  endtask
  // lat counts falling edges after the accept edge until res_valid is seen, bounded at 200.
  task automatic run_mdu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input bit hold);
    drive(c, x, y);
    @(negedge clk);
    if (hold) drive(OP_ADD, 32'd2, 32'd3);
    else in_valid = 1'b0;
    lat = 1;
    busy = int'(!in_ready);
    busy8 = int'(!in_ready8);
    lat8 = res_valid8 ? 1 : 0;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      busy += int'(!in_ready);
      busy8 += int'(!in_ready8);
      if (res_valid8 && lat8 == 0) lat8 = lat;
    end
  endtask
  initial begin
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_hi_lo", {hi, lo}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_flags", {zero, ovf, div0}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], 32'hF, 32'h3);
      @(negedge clk);
      e = exps[i];
      chk($sformatf("basic%0d_result", i), result, e);
      chk($sformatf("basic%0d_valid", i), {res_valid, in_ready, zero}, 3'b110);
      chk($sformatf("basic%0d_result8", i), result8, e[7:0]);
      chk($sformatf("basic%0d_valid8", i), {res_valid8, in_ready8}, 2'b11);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_valid", res_valid, 0);
    drive(OP_ADD, 32'h7FFFFFFF, 32'h1);
    @(negedge clk);
    chk("add_ovf_result", result, 32'h80000000);
    chk("add_ovf", ovf, 1);
    drive(OP_SLT, 32'h80000000, 32'h7FFFFFFF);
    @(negedge clk);
    chk("slt_result", result, 1);
    chk("slt_ovf", ovf, 0);
    drive(OP_SUB, 32'd5, 32'd5);
    @(negedge clk);
    chk("sub_zero", {result, zero, ovf}, {32'h0, 2'b10});
    drive(OP_SUB, 32'h80000000, 32'h1);
    @(negedge clk);
    chk("sub_ovf", {result, ovf}, {32'h7FFFFFFF, 1'b1});
    drive(4'b1111, 32'hF0, 32'h3C);
    @(negedge clk);
    chk("illegal_as_and", result, 32'h30);
    run_mdu(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("mul_latency", lat, 33);
    chk("mul_busy_cycles", busy, 32);
    chk("mul_hi", hi, 32'hFFFFFFFE);
    chk("mul_lo", lo, 32'h1);
    chk("mul_result_zero", {result, zero}, {32'h1, 1'b0});
    chk("mul8_latency", lat8, 9);
    chk("mul8_busy_cycles", busy8, 8);
    chk("mul8_hi_lo", {hi8, lo8}, 16'hFE01);
    @(negedge clk);
    in_valid = 1'b0;
    chk("held_add_result", {res_valid, result}, {1'b1, 32'd5});
    chk("held_add_keeps_hilo", {hi, lo}, {32'hFFFFFFFE, 32'h1});
    run_mdu(OP_DIVU, 32'd100, 32'd7, 1'b0);
    chk("div_latency", lat, 33);
    chk("div_lo_hi", {lo, hi}, {32'd14, 32'd2});
    chk("div_result_div0", {result, div0}, {32'd14, 1'b0});
    run_mdu(OP_DIVU, 32'h1234, 32'h0, 1'b0);
    chk("div0_latency", lat, 2);
    chk("div0_lo_hi", {lo, hi}, {32'hFFFFFFFF, 32'h1234});
    chk("div0_flag", {result, div0}, {32'hFFFFFFFF, 1'b1});
    drive(OP_ADD, 32'd2, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    chk("add_clears_div0", {result, div0}, {32'd5, 1'b0});
    chk("add_keeps_hi", hi, 32'h1234);
    drive(OP_MULTU, 32'd3, 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_result", result, 0);
    chk("async_rst_hi_lo", {hi, lo}, 0);
    chk("async_rst_hs", {in_ready, res_valid, div0}, 3'b100);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      cnt += int'(res_valid);
    end
    chk("no_valid_after_abort", cnt, 0);
    drive(OP_ADD, 32'd20, 32'd22);
    @(negedge clk);
    in_valid = 1'b0;
    chk("add_after_reset", {res_valid, result}, {1'b1, 32'd42});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
